// File: rtl/morra_pkg.sv
// Shared encodings, result codes and match rules for the morra_cinese referee.
package morra_pkg;

    // Move encodings
    localparam logic [1:0] MOVE_NONE = 2'b00;
    localparam logic [1:0] ROCK      = 2'b01;
    localparam logic [1:0] PAPER     = 2'b10;
    localparam logic [1:0] SCISSORS  = 2'b11;

    // Round result codes (also used as the last-winner record)
    localparam logic [1:0] RES_NONE = 2'b00;
    localparam logic [1:0] RES_P1   = 2'b01;
    localparam logic [1:0] RES_P2   = 2'b10;
    localparam logic [1:0] RES_DRAW = 2'b11;

    // Match result codes
    localparam logic [1:0] MATCH_OPEN = 2'b00;
    localparam logic [1:0] MATCH_P1   = 2'b01;
    localparam logic [1:0] MATCH_P2   = 2'b10;
    localparam logic [1:0] MATCH_DRAW = 2'b11;

    // Termination rule constants, sized to the 5-bit counters
    localparam logic [4:0] MIN_ROUNDS  = 5'd4;
    localparam logic [4:0] LEAD_TO_WIN = 5'd2;

    typedef enum logic {
        StIdle,
        StPlay
    } state_t;

    // True when move a beats move b (both assumed valid)
    function automatic logic beats(input logic [1:0] a, input logic [1:0] b);
        return (a == ROCK && b == SCISSORS) ||
               (a == SCISSORS && b == PAPER) ||
               (a == PAPER && b == ROCK);
    endfunction

endpackage

// File: rtl/manche_judge.sv
// Combinational round judge: validity, repeat restriction and winner decision.
module manche_judge
    import morra_pkg::*;
(
    input  logic [1:0] g1,
    input  logic [1:0] g2,
    input  logic [1:0] last_win,
    input  logic [1:0] last_move,
    output logic [1:0] round_code
);

    // Invalid moves and a winner repeating its winning move void the round
    always_comb begin
        round_code = RES_NONE;
        if (g1 == MOVE_NONE || g2 == MOVE_NONE) begin
            round_code = RES_NONE;
        end else if (last_win == RES_P1 && g1 == last_move) begin
            round_code = RES_NONE;
        end else if (last_win == RES_P2 && g2 == last_move) begin
            round_code = RES_NONE;
        end else if (g1 == g2) begin
            round_code = RES_DRAW;
        end else if (beats(g1, g2)) begin
            round_code = RES_P1;
        end else begin
            round_code = RES_P2;
        end
    end

endmodule

// File: rtl/morra_cinese.sv
// Rock-paper-scissors match referee: FSM, score counters and registered results.
module morra_cinese
    import morra_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] g1,
    input  logic [1:0] g2,
    output logic [1:0] manche,
    output logic [1:0] partita
);

    state_t     state;
    logic [4:0] max_rounds;
    logic [4:0] played;
    logic [4:0] win1;
    logic [4:0] win2;
    logic [1:0] last_win;
    logic [1:0] last_move;

    logic [1:0] round_code;
    logic       round_valid;
    logic [4:0] played_nx;
    logic [4:0] win1_nx;
    logic [4:0] win2_nx;
    logic [4:0] lead_nx;
    logic       match_done;
    logic [1:0] match_code;

    manche_judge u_judge (
        .g1         (g1),
        .g2         (g2),
        .last_win   (last_win),
        .last_move  (last_move),
        .round_code (round_code)
    );

    // Score after this round, and whether it ends the match
    always_comb begin
        round_valid = (round_code != RES_NONE);
        played_nx   = played + 5'd1;
        win1_nx     = win1 + {4'd0, round_code == RES_P1};
        win2_nx     = win2 + {4'd0, round_code == RES_P2};
        lead_nx     = (win1_nx > win2_nx) ? (win1_nx - win2_nx) : (win2_nx - win1_nx);
        match_done  = ((played_nx >= MIN_ROUNDS) && (lead_nx >= LEAD_TO_WIN)) ||
                      (played_nx == max_rounds);
        if (win1_nx > win2_nx) begin
            match_code = MATCH_P1;
        end else if (win2_nx > win1_nx) begin
            match_code = MATCH_P2;
        end else begin
            match_code = MATCH_DRAW;
        end
    end

    // Match FSM with counters and registered outputs; reset also loads the match length
    always_ff @(posedge clk) begin
        if (reset) begin
            max_rounds <= {1'b0, g1, g2} + 5'd4;
            played     <= 5'd0;
            win1       <= 5'd0;
            win2       <= 5'd0;
            last_win   <= RES_NONE;
            last_move  <= MOVE_NONE;
            state      <= StPlay;
            manche     <= RES_NONE;
            partita    <= MATCH_OPEN;
        end else begin
            unique case (state)
                StIdle: begin
                    manche  <= RES_NONE;
                    partita <= MATCH_OPEN;
                end
                StPlay: begin
                    manche  <= round_code;
                    partita <= MATCH_OPEN;
                    if (round_valid) begin
                        played   <= played_nx;
                        win1     <= win1_nx;
                        win2     <= win2_nx;
                        last_win <= (round_code == RES_DRAW) ? RES_NONE : round_code;
                        if (round_code == RES_P1) begin
                            last_move <= g1;
                        end else if (round_code == RES_P2) begin
                            last_move <= g2;
                        end else begin
                            last_move <= MOVE_NONE;
                        end
                        if (match_done) begin
                            partita <= match_code;
                            state   <= StIdle;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_morra_cinese.sv
// Self-checking bench for morra_cinese: vector table plus hand-written match sequences.
module tb_morra_cinese;

    logic       clk;
    logic       reset;
    logic [1:0] g1;
    logic [1:0] g2;
    logic [1:0] manche;
    logic [1:0] partita;

    morra_cinese dut (
        .clk     (clk),
        .reset   (reset),
        .g1      (g1),
        .g2      (g2),
        .manche  (manche),
        .partita (partita)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [1:0] m1;
        logic [1:0] m2;
        logic [1:0] exp_manche;
        logic [1:0] exp_partita;
    } vec_t;

    typedef struct {
        logic [1:0] exp_manche;
        logic [1:0] exp_partita;
        int         idx;
    } exp_t;

    localparam logic [1:0] N = 2'b00;
    localparam logic [1:0] R = 2'b01;
    localparam logic [1:0] P = 2'b10;
    localparam logic [1:0] S = 2'b11;

    vec_t vecs[$];
    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   step_no = 0;

    task automatic add(input logic rst, input logic [1:0] a, input logic [1:0] b,
                       input logic [1:0] em, input logic [1:0] ep);
        vec_t v;
        v.rst = rst;
        v.m1 = a;
        v.m2 = b;
        v.exp_manche = em;
        v.exp_partita = ep;
        vecs.push_back(v);
    endtask

    // Drive one cycle, queue its expectation, then compare once the edge has passed
    task automatic apply(input logic rst, input logic [1:0] a, input logic [1:0] b,
                         input logic [1:0] em, input logic [1:0] ep);
        exp_t e;
        exp_t got;
        reset = rst;
        g1 = a;
        g2 = b;
        e.exp_manche = em;
        e.exp_partita = ep;
        e.idx = step_no;
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        checks++;
        if (manche !== got.exp_manche) begin
            errors++;
            $display("FAIL manche step %0d: got %b expected %b", got.idx, manche,
                     got.exp_manche);
        end
        checks++;
        if (partita !== got.exp_partita) begin
            errors++;
            $display("FAIL partita step %0d: got %b expected %b", got.idx, partita,
                     got.exp_partita);
        end
        step_no++;
    endtask

    initial begin
        reset = 1'b0;
        g1 = N;
        g2 = N;

        // Match A: max=4, repeat restriction and draw clearing it, ends on max with a tie
        add(1, N, N, 2'b00, 2'b00);
        add(0, R, P, 2'b10, 2'b00);
        add(0, S, P, 2'b00, 2'b00);
        add(0, S, P, 2'b00, 2'b00);
        add(0, S, S, 2'b11, 2'b00);
        add(0, R, R, 2'b11, 2'b00);
        add(0, P, R, 2'b01, 2'b11);
        add(0, R, S, 2'b00, 2'b00);
        // Match B: max=5, player 2 ahead by two after four rounds
        add(1, N, R, 2'b00, 2'b00);
        add(0, S, P, 2'b01, 2'b00);
        add(0, P, S, 2'b10, 2'b00);
        add(0, R, P, 2'b10, 2'b00);
        add(0, S, R, 2'b10, 2'b10);
        add(0, P, R, 2'b00, 2'b00);
        // Match C: max=5 reached at 2-2 on a draw, invalid moves in between
        add(1, N, R, 2'b00, 2'b00);
        add(0, R, S, 2'b01, 2'b00);
        add(0, N, S, 2'b00, 2'b00);
        add(0, P, S, 2'b10, 2'b00);
        add(0, P, R, 2'b01, 2'b00);
        add(0, R, P, 2'b10, 2'b00);
        add(0, R, R, 2'b11, 2'b11);
        add(0, S, P, 2'b00, 2'b00);

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i].rst, vecs[i].m1, vecs[i].m2, vecs[i].exp_manche,
                  vecs[i].exp_partita);
        end

        // Lead rule: max=19, three straight P1 wins keep the match open, the fourth ends it
        apply(1, S, S, 2'b00, 2'b00);
        apply(0, R, S, 2'b01, 2'b00);
        apply(0, P, R, 2'b01, 2'b00);
        apply(0, S, P, 2'b01, 2'b00);
        apply(0, R, S, 2'b01, 2'b01);
        apply(0, R, S, 2'b00, 2'b00);
        apply(0, P, R, 2'b00, 2'b00);

        // Reset mid-match clears counters and last-winner record
        apply(1, S, S, 2'b00, 2'b00);
        apply(0, R, S, 2'b01, 2'b00);
        apply(0, P, S, 2'b10, 2'b00);
        apply(1, S, S, 2'b00, 2'b00);
        apply(0, R, S, 2'b01, 2'b00);
        apply(0, P, P, 2'b11, 2'b00);
        apply(0, P, R, 2'b01, 2'b00);
        apply(0, S, P, 2'b01, 2'b01);

        // Max reached with alternating winners, then IDLE ignores moves until reset
        apply(1, N, N, 2'b00, 2'b00);
        apply(0, R, S, 2'b01, 2'b00);
        apply(0, R, P, 2'b00, 2'b00);
        apply(0, P, S, 2'b10, 2'b00);
        apply(0, P, R, 2'b01, 2'b00);
        apply(0, S, R, 2'b10, 2'b11);
        apply(0, R, S, 2'b00, 2'b00);
        apply(0, P, S, 2'b00, 2'b00);
        apply(0, S, S, 2'b00, 2'b00);
        apply(1, N, N, 2'b00, 2'b00);
        apply(0, R, S, 2'b01, 2'b00);

        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard drain: got %0d pending expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
